// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants for the PC sequencer.
package cpu_pkg;

  localparam int          PC_W     = 5;
  localparam int unsigned RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux; also flags an all-ones to zero increment.
// With PC_SEQ_LINK_EN defined, call/ret redirects and the link write enable are added.
module pc_next_sel #(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic            accept,
  input  logic            halt_req,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
`ifdef PC_SEQ_LINK_EN
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] link,
  output logic            link_we,
  output logic [PC_W-1:0] link_next,
`endif
  output logic [PC_W-1:0] pc_next,
  output logic            wrap_next
);

  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc + PC_W'(1);

`ifdef PC_SEQ_LINK_EN
  assign link_next = pc_inc;
`endif

  // A halting cycle still retires an accepted fetch, so it may increment and wrap.
  always_comb begin
    pc_next   = pc;
    wrap_next = 1'b0;
`ifdef PC_SEQ_LINK_EN
    link_we   = 1'b0;
`endif
    if (halt_req) begin
      if (accept) begin
        pc_next   = pc_inc;
        wrap_next = &pc;
      end
    end
`ifdef PC_SEQ_LINK_EN
    else if (ret) begin
      pc_next = link;
    end else if (call) begin
      pc_next = jmp_target;
      link_we = 1'b1;
    end
`endif
    else if (jmp) begin
      pc_next = jmp_target;
    end else if (br_taken) begin
      pc_next = br_target;
    end else if (accept) begin
      pc_next   = pc_inc;
      wrap_next = &pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequences increment/branch/jump/stall/halt and issues fetches.
// Optional call/ret link register is enabled by defining PC_SEQ_LINK_EN.
module pc_sequencer #(
  parameter int          PC_W     = cpu_pkg::PC_W,
  parameter int unsigned RESET_PC = cpu_pkg::RESET_PC,
  parameter int          CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             jmp,
  input  logic [PC_W-1:0]  jmp_target,
  input  logic             fetch_ready,
`ifdef PC_SEQ_LINK_EN
  input  logic             call,
  input  logic             ret,
`endif
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             halted,
  output logic             wrap,
  output logic [CNT_W-1:0] fetch_cnt
);

  import cpu_pkg::*;

  localparam logic [PC_W-1:0] RESET_VAL = RESET_PC[PC_W-1:0];

  state_t          state, state_next;
  logic            accept;
  logic            run;
  logic [PC_W-1:0] pc_next;
  logic            wrap_next;

  assign run         = (state == RUN);
  assign fetch_valid = run && !stall;
  assign halted      = (state == HALT);
  assign accept      = fetch_valid && fetch_ready;

`ifdef PC_SEQ_LINK_EN
  logic [PC_W-1:0] link;
  logic [PC_W-1:0] link_next;
  logic            link_we;
`endif

  pc_next_sel #(.PC_W(PC_W)) u_sel (
    .pc         (pc),
    .accept     (accept),
    .halt_req   (halt_req),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
`ifdef PC_SEQ_LINK_EN
    .call       (call),
    .ret        (ret),
    .link       (link),
    .link_we    (link_we),
    .link_next  (link_next),
`endif
    .pc_next    (pc_next),
    .wrap_next  (wrap_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // In RUN halt_req beats start; from IDLE/HALT start is the only way out.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (halt_req) state_next = HALT;
      HALT:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_VAL;
      wrap      <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      wrap <= 1'b0;
      if (run) begin
        pc   <= pc_next;
        wrap <= wrap_next;
      end
      if (accept && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

`ifdef PC_SEQ_LINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              link <= '0;
    else if (run && link_we) link <= link_next;
  end
`endif

endmodule
